// File: rtl/ram_burst_pkg.sv
// Shared types and sizing for the RAM burst master.
//   state_e       : burst sequencer states
//   RD_FIFO_DEPTH : read-return buffer depth; also caps reads in flight
//   RD_CNT_W      : width of an occupancy count 0..RD_FIFO_DEPTH
//   RD_PTR_W      : width of a FIFO slot index
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int RD_FIFO_DEPTH = 4;
  localparam int RD_CNT_W      = $clog2(RD_FIFO_DEPTH + 1);
  localparam int RD_PTR_W      = $clog2(RD_FIFO_DEPTH);

endpackage

// File: rtl/ram_burst_rd_fifo.sv
// Read-return FIFO for the RAM burst master.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : data to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (meaningful when count != 0)
//   count      : number of stored entries, 0..RD_FIFO_DEPTH
module ram_burst_rd_fifo
  import ram_burst_pkg::*;
#(
  parameter int datawidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [datawidth-1:0] push_data,
  input  logic                 pop,
  output logic [datawidth-1:0] head,
  output logic [RD_CNT_W-1:0]  count
);

  logic [datawidth-1:0] mem_r [RD_FIFO_DEPTH];
  logic [RD_PTR_W-1:0]  wr_ptr_r;
  logic [RD_PTR_W-1:0]  rd_ptr_r;
  logic [RD_CNT_W-1:0]  count_r;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  assign push_ok_s = push && (count_r != RD_CNT_W'(RD_FIFO_DEPTH));
  assign pop_ok_s  = pop  && (count_r != RD_CNT_W'(0));
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array: data only, no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= RD_PTR_W'(0);
      rd_ptr_r <= RD_PTR_W'(0);
      count_r  <= RD_CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + RD_PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + RD_PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + RD_CNT_W'(1);
        2'b01:   count_r <= count_r - RD_CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM with a one-cycle read latency.
// Accepts (addr, len, write) commands and sequences ram_address/ren/wen/data_in.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len: burst command; beats = cmd_len + 1
//   wr_valid/ready/data           : write beat stream (ready only while writing)
//   rd_valid/ready/data           : read beat stream, buffered with backpressure
//   busy                          : a burst is in progress
//   done                          : one-cycle pulse when a burst completes
//   ram_address/ren/wen/data_in   : registered RAM control and write data
//   ram_data_out                  : RAM read data, valid the cycle after ren
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int addrwidth = 8,
  parameter int datawidth = 8,
  parameter int lenwidth  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrwidth-1:0] cmd_addr,
  input  logic [lenwidth-1:0]  cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [datawidth-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [datawidth-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [addrwidth-1:0] ram_address,
  output logic                 ram_ren,
  output logic                 ram_wen,
  output logic [datawidth-1:0] ram_data_in,
  input  logic [datawidth-1:0] ram_data_out
);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [addrwidth-1:0] addr_r;
  logic [lenwidth-1:0]  remaining_r;
  logic [RD_CNT_W-1:0]  outstanding_r;
  logic                 cap_r;
  logic                 done_wr_r;
  logic [addrwidth-1:0] ram_address_r;
  logic                 ram_ren_r;
  logic                 ram_wen_r;
  logic [datawidth-1:0] ram_data_in_r;

  logic                 cmd_hs_s;
  logic                 wr_hs_s;
  logic                 issue_s;
  logic                 room_s;
  logic                 last_beat_s;
  logic                 pop_s;
  logic                 last_pop_s;
  logic [RD_CNT_W-1:0]  fifo_count_s;
  logic [RD_CNT_W:0]    committed_s;

  assign cmd_ready   = (state_r == IDLE);
  assign wr_ready    = (state_r == WRITE);
  assign busy        = (state_r != IDLE);
  assign cmd_hs_s    = cmd_valid && cmd_ready;
  assign wr_hs_s     = wr_valid && wr_ready;
  assign last_beat_s = (remaining_r == lenwidth'(0));

  // Buffered beats plus reads still in the RAM pipeline must fit in the FIFO,
  // so a read is only issued when its data is guaranteed a slot.
  assign committed_s = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
  assign room_s      = (committed_s < (RD_CNT_W + 1)'(RD_FIFO_DEPTH));
  assign issue_s     = (state_r == READ) && room_s;

  assign rd_valid    = (fifo_count_s != RD_CNT_W'(0));
  assign pop_s       = rd_valid && rd_ready;

  // The final read beat is the only one left once nothing is in flight.
  assign last_pop_s  = (state_r == DRAIN) && (outstanding_r == RD_CNT_W'(0)) &&
                       (fifo_count_s == RD_CNT_W'(1)) && pop_s;

  // Write completion is registered alongside ram_wen; read completion is
  // tied to the consumer's final handshake, so it is decoded combinationally.
  assign done        = done_wr_r || last_pop_s;

  assign ram_address = ram_address_r;
  assign ram_ren     = ram_ren_r;
  assign ram_wen     = ram_wen_r;
  assign ram_data_in = ram_data_in_r;

  ram_burst_rd_fifo #(
    .datawidth (datawidth)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_r),
    .push_data (ram_data_out),
    .pop       (pop_s),
    .head      (rd_data),
    .count     (fifo_count_s)
  );

  // Next-state decode for the burst sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) begin
          if (cmd_write) begin
            state_nxt_s = WRITE;
          end else begin
            state_nxt_s = READ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (wr_hs_s && last_beat_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (issue_s && last_beat_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (last_pop_s ||
            ((outstanding_r == RD_CNT_W'(0)) && (fifo_count_s == RD_CNT_W'(0)))) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, burst address/count, in-flight tracking and registered RAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      addr_r        <= addrwidth'(0);
      remaining_r   <= lenwidth'(0);
      outstanding_r <= RD_CNT_W'(0);
      cap_r         <= 1'b0;
      done_wr_r     <= 1'b0;
      ram_address_r <= addrwidth'(0);
      ram_ren_r     <= 1'b0;
      ram_wen_r     <= 1'b0;
      ram_data_in_r <= datawidth'(0);
    end else begin
      state_r <= state_nxt_s;

      if (cmd_hs_s) begin
        addr_r      <= cmd_addr;
        remaining_r <= cmd_len;
      end else if (wr_hs_s || issue_s) begin
        addr_r      <= addr_r + addrwidth'(1);
        remaining_r <= remaining_r - lenwidth'(1);
      end

      if (wr_hs_s || issue_s) begin
        ram_address_r <= addr_r;
      end
      if (wr_hs_s) begin
        ram_data_in_r <= wr_data;
      end
      ram_wen_r <= wr_hs_s;
      ram_ren_r <= issue_s;
      done_wr_r <= wr_hs_s && last_beat_s;

      // ram_data_out carries the read the cycle after ren was high.
      cap_r <= ram_ren_r;

      case ({issue_s, cap_r})
        2'b10:   outstanding_r <= outstanding_r + RD_CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - RD_CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, done;
  logic [7:0] ram_address;
  logic       ram_ren, ram_wen;
  logic [7:0] ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  ram_burst_master #(.addrwidth(8), .datawidth(8), .lenwidth(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_address(ram_address), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Behavioural single-port RAM: registered read, data valid cycle after ren.
  logic [7:0] env_mem [256];
  logic       ram_init;
  logic [7:0] seed8;

  function automatic logic [7:0] seed_byte(input int i, input logic [7:0] s);
    return 8'(i * 37 + 11) ^ s;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= seed_byte(i, seed8);
    end else begin
      if (ram_wen) env_mem[ram_address] <= ram_data_in;
      if (ram_ren) ram_data_out <= env_mem[ram_address];
    end
  end

  // Reference model: expected RAM contents after each burst.
  logic [7:0] ref_mem [256];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: wr_valid always high, 1: alternating 1,0,1,..., 2: random
  task automatic write_burst(input logic [7:0] a, input int len, input int mode,
                             input bit fixed_data, input logic [7:0] dbase);
    int n, sent, cyc, budget;
    logic v, alt, hs, exp_wen, exp_done;
    logic [7:0] exp_a, exp_d;
    n = len + 1; sent = 0; cyc = 0; budget = 20 * n + 50;
    alt = 1'b1; exp_wen = 1'b0; exp_done = 1'b0; exp_a = 8'h00; exp_d = 8'h00;
    @(negedge clk);
    check_eq("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = 8'(len);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
    while ((sent < n || exp_wen) && cyc < budget) begin
      check_eq("wr_ram_wen", 32'(ram_wen), 32'(exp_wen));
      if (exp_wen) begin
        check_eq("wr_ram_address", 32'(ram_address), 32'(exp_a));
        check_eq("wr_ram_data_in", 32'(ram_data_in), 32'(exp_d));
      end
      check_eq("wr_done", 32'(done), 32'(exp_done));
      check_eq("wr_ram_ren", 32'(ram_ren), 32'd0);
      check_eq("wr_rd_valid", 32'(rd_valid), 32'd0);
      if (exp_done) begin
        check_eq("wr_end_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("wr_end_busy", 32'(busy), 32'd0);
      end
      if (sent < n) begin
        check_eq("wr_ready", 32'(wr_ready), 32'd1);
        check_eq("wr_busy", 32'(busy), 32'd1);
        v = (mode == 0) ? 1'b1 : (mode == 1) ? alt : 1'($urandom_range(1));
      end else begin
        v = 1'b0;
      end
      alt = ~alt;
      wr_valid = v;
      wr_data  = fixed_data ? 8'(dbase + 8'(sent)) : 8'($urandom);
      rd_ready = 1'($urandom_range(1));
      hs = v && wr_ready;
      exp_wen  = hs;
      exp_a    = 8'(a + 8'(sent));
      exp_d    = wr_data;
      exp_done = hs && (sent == n - 1);
      if (hs) begin
        ref_mem[exp_a] = wr_data;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    check_eq("wr_beats", 32'(sent), 32'(n));
  endtask

  task automatic read_burst(input logic [7:0] a, input int len, input int stall,
                            input int ready_pct, input int abort_after);
    logic [7:0] exp_q[$];
    int n, issued, got, cyc, budget, first_hs, last_hs;
    logic hs;
    n = len + 1; issued = 0; got = 0; cyc = 0; budget = 40 * n + 100 + stall;
    first_hs = -1; last_hs = -1;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[8'(a + 8'(i))]);
    @(negedge clk);
    check_eq("rd_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = 8'(len);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
    while (got < n && cyc < budget) begin
      rd_ready = (cyc < stall) ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
      wr_valid = 1'($urandom_range(1));
      wr_data  = 8'($urandom);
      #1;
      check_eq("rd_ram_wen", 32'(ram_wen), 32'd0);
      check_eq("rd_wr_ready", 32'(wr_ready), 32'd0);
      if (ram_ren) begin
        check_eq("rd_ram_address", 32'(ram_address), 32'(8'(a + 8'(issued))));
        issued++;
      end
      check_eq("rd_inflight_le_4", 32'(issued - got > 4), 32'd0);
      if (stall >= 5 && cyc == stall)
        check_eq("rd_ren_during_stall", 32'(issued), 32'((n < 4) ? n : 4));
      hs = rd_valid && rd_ready;
      if (hs) begin
        check_eq("rd_data", 32'(rd_data), 32'(exp_q[got]));
        check_eq("rd_done", 32'(done), 32'(got == n - 1));
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        got++;
      end else begin
        check_eq("rd_done_idle", 32'(done), 32'd0);
      end
      if (abort_after > 0 && got == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        rd_ready = 1'b1;
        #1;
        check_eq("abort_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          #1;
          check_eq("abort_quiet_done", 32'(done), 32'd0);
          check_eq("abort_quiet_rd_valid", 32'(rd_valid), 32'd0);
          check_eq("abort_quiet_ren", 32'(ram_ren), 32'd0);
        end
        rd_ready = 1'b0; wr_valid = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0; wr_valid = 1'b0;
    #1;
    check_eq("rd_beats", 32'(got), 32'(n));
    check_eq("rd_issued", 32'(issued), 32'(n));
    check_eq("rd_end_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rd_end_busy", 32'(busy), 32'd0);
    check_eq("rd_end_rd_valid", 32'(rd_valid), 32'd0);
    if (ready_pct >= 100 && stall == 0)
      check_eq("rd_throughput", 32'(last_hs - first_hs), 32'(n - 1));
  endtask

  logic [7:0] ra;
  int         rlen;

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 8'h00;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    seed8 = 8'($urandom);
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_byte(i, seed8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ram_ren", 32'(ram_ren), 32'd0);
    check_eq("rst_ram_wen", 32'(ram_wen), 32'd0);
    check_eq("rst_ram_address", 32'(ram_address), 32'd0);
    check_eq("rst_ram_data_in", 32'(ram_data_in), 32'd0);
    ram_init = 1'b0; rst = 1'b0;

    write_burst(8'h10, 3, 0, 1'b1, 8'hA0);
    read_burst(8'h10, 3, 0, 100, 0);
    read_burst(8'h20, 7, 10, 100, 0);
    write_burst(8'hFE, 2, 0, 1'b0, 8'h00);
    write_burst(8'h40, 2, 1, 1'b0, 8'h00);
    read_burst(8'hFE, 2, 0, 100, 0);
    read_burst(8'h30, 7, 0, 100, 2);
    read_burst(8'h50, 0, 0, 100, 0);
    write_burst(8'hF0, 255, 2, 1'b0, 8'h00);
    read_burst(8'hF0, 255, 0, 100, 0);

    for (int it = 0; it < 24; it++) begin
      ra   = 8'($urandom);
      rlen = int'($urandom_range(15));
      if ($urandom_range(1) == 1)
        write_burst(ra, rlen, int'($urandom_range(2)), 1'b0, 8'h00);
      else
        read_burst(ra, rlen, int'($urandom_range(10)), int'($urandom_range(100, 30)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
